// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PERF_W = 32;

  localparam int unsigned PIPE_CTRL_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline <-> controller bundle: hazard inputs from ID/EX/MEM, hold/bubble controls back.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memr;
  logic             br_taken;
  logic             mem_req;
  logic             dmem_ready;

  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_stall;
  logic mem_wb_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic mem_timeout;

  // Pipeline side
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memr,
           br_taken, mem_req, dmem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memr,
           br_taken, mem_req, dmem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and a load's destination in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memr,
  output logic             load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // x0 is never written, so a load to x0 can not create a dependency
  assign load_use_c = ex_memr && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush controller with dmem wait timeout.
// Optional performance counters are built in when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = PIPE_CTRL_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events,
`endif
  pipe_ctrl_if.slave        bus
);

  pipe_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use_c;
  logic mem_wait_c;

  logic pc_stall_c;
  logic if_id_stall_c;
  logic id_ex_stall_c;
  logic ex_mem_stall_c;
  logic mem_wb_stall_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic ex_mem_flush_c;
  logic mem_wb_flush_c;
  logic mem_timeout_c;

  hazard_detect u_hazard_detect (
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .ex_rd      (bus.ex_rd),
    .ex_memr    (bus.ex_memr),
    .load_use_c (load_use_c)
  );

  assign mem_wait_c = bus.mem_req && !bus.dmem_ready;

  // State and wait-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and zero-latency stall/flush decode; priority ERROR > wait > branch > load-use
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_wb_stall_c = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    mem_timeout_c  = 1'b0;

    if (rst) begin
      state_d        = RUN;
      cnt_d          = '0;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else begin
      unique case (state_q)
        ERROR: begin
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_stall_c  = 1'b1;
          ex_mem_stall_c = 1'b1;
          mem_wb_stall_c = 1'b1;
          mem_timeout_c  = 1'b1;
        end

        RUN, MEM_WAIT: begin
          if (mem_wait_c) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_stall_c = 1'b1;
            mem_wb_flush_c = 1'b1;
            // cnt_q holds the number of wait cycles already spent
            if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
              state_d = ERROR;
            end else begin
              state_d = MEM_WAIT;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            if (bus.br_taken) begin
              if_id_flush_c = 1'b1;
              id_ex_flush_c = 1'b1;
            end else if (load_use_c) begin
              pc_stall_c    = 1'b1;
              if_id_stall_c = 1'b1;
              id_ex_flush_c = 1'b1;
            end
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.pc_stall     = pc_stall_c;
  assign bus.if_id_stall  = if_id_stall_c;
  assign bus.id_ex_stall  = id_ex_stall_c;
  assign bus.ex_mem_stall = ex_mem_stall_c;
  assign bus.mem_wb_stall = mem_wb_stall_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_flush  = id_ex_flush_c;
  assign bus.ex_mem_flush = ex_mem_flush_c;
  assign bus.mem_wb_flush = mem_wb_flush_c;
  assign bus.mem_timeout  = mem_timeout_c;

`ifdef PIPE_CTRL_PERF_EN
  // Free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      stall_cycles <= stall_cycles + PERF_W'(pc_stall_c);
      flush_events <= flush_events + PERF_W'(if_id_flush_c || id_ex_flush_c);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, corner sequences, then random traffic vs a reference model.
module tb_pipe_ctrl;

  localparam int unsigned T = 4;

  // Output vector: {pc,if_id,id_ex,ex_mem,mem_wb stalls, if_id,id_ex,ex_mem,mem_wb flushes, timeout}
  localparam logic [9:0] O_RST  = 10'b00000_1111_0;
  localparam logic [9:0] O_NONE = 10'b00000_0000_0;
  localparam logic [9:0] O_LU   = 10'b11000_0100_0;
  localparam logic [9:0] O_BR   = 10'b00000_1100_0;
  localparam logic [9:0] O_MW   = 10'b11110_0001_0;
  localparam logic [9:0] O_ERR  = 10'b11111_0000_1;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] ex_rd;
    logic       memr;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [9:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: error latch, consecutive wait count, perf counts
  bit          m_err = 1'b0;
  int          m_wc  = 0;
  logic [31:0] m_sc  = '0;
  logic [31:0] m_fe  = '0;

  pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  pipe_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(bit r, int rs1, int rs2, bit u1, bit u2, int rd,
                             bit memr, bit br, bit req, bit rdy);
    in_t x;
    x.rst = r; x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.use1 = u1; x.use2 = u2;
    x.ex_rd = 5'(rd); x.memr = memr; x.br = br; x.req = req; x.rdy = rdy;
    return x;
  endfunction

  function automatic logic [9:0] model_out(in_t x);
    bit lu;
    lu = x.memr && (x.ex_rd != 0) &&
         ((x.use1 && x.rs1 == x.ex_rd) || (x.use2 && x.rs2 == x.ex_rd));
    if (x.rst) return O_RST;
    if (m_err) return O_ERR;
    if (x.req && !x.rdy) return O_MW;
    if (x.br) return O_BR;
    if (lu) return O_LU;
    return O_NONE;
  endfunction

  task automatic model_update(in_t x, logic [9:0] o);
    if (x.rst) begin
      m_err = 1'b0; m_wc = 0; m_sc = '0; m_fe = '0;
    end else begin
      m_sc = m_sc + 32'(o[9]);
      m_fe = m_fe + 32'(o[4] | o[3]);
      if (!m_err) begin
        if (x.req && !x.rdy) begin
          m_wc++;
          if (m_wc > int'(T)) m_err = 1'b1;
        end else begin
          m_wc = 0;
        end
      end
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_out();
    return {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall, bus.mem_wb_stall,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush, bus.mem_timeout};
  endfunction

  // One cycle: drive on negedge, compare after settling, advance model
  task automatic step(in_t x, logic [9:0] exp, bit use_model, string name);
    logic [9:0] m;
    @(negedge clk);
    rst            = x.rst;
    bus.id_rs1     = x.rs1;
    bus.id_rs2     = x.rs2;
    bus.id_use_rs1 = x.use1;
    bus.id_use_rs2 = x.use2;
    bus.ex_rd      = x.ex_rd;
    bus.ex_memr    = x.memr;
    bus.br_taken   = x.br;
    bus.mem_req    = x.req;
    bus.dmem_ready = x.rdy;
    #1;
    m = model_out(x);
    check(name, 32'(dut_out()), 32'(use_model ? m : exp));
`ifdef PIPE_CTRL_PERF_EN
    check({name, "_stall_cnt"}, stall_cycles, m_sc);
    check({name, "_flush_cnt"}, flush_events, m_fe);
`endif
    model_update(x, m);
  endtask

  vec_t tab[13];
  in_t  idle, wt, rs;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    wt   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rs   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    tab[0]  = '{rs,                                    O_RST,  "reset"};
    tab[1]  = '{idle,                                  O_NONE, "idle"};
    tab[2]  = '{mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 1),      O_LU,   "lu_rs1"};
    tab[3]  = '{mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1),      O_NONE, "lu_rd0"};
    tab[4]  = '{mk(0, 3, 7, 0, 1, 7, 1, 0, 0, 1),      O_LU,   "lu_rs2"};
    tab[5]  = '{mk(0, 5, 0, 0, 0, 5, 1, 0, 0, 1),      O_NONE, "lu_unused"};
    tab[6]  = '{mk(0, 5, 0, 1, 0, 5, 0, 0, 0, 1),      O_NONE, "no_load"};
    tab[7]  = '{mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 1),      O_BR,   "br_over_lu"};
    tab[8]  = '{mk(0, 5, 0, 1, 0, 5, 1, 1, 1, 0),      O_MW,   "wait1_br_lu"};
    tab[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0),      O_MW,   "wait2_br"};
    tab[10] = '{wt,                                    O_MW,   "wait3"};
    tab[11] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1),      O_BR,   "wait_done_br"};
    tab[12] = '{idle,                                  O_NONE, "idle_after"};

    for (int k = 0; k < 13; k++) step(tab[k].i, tab[k].exp, 1'b0, tab[k].name);

    // Timeout: T+1 wait cycles pass, then sticky ERROR until reset
    step(rs, O_RST, 1'b0, "to_reset");
    for (int k = 0; k <= int'(T); k++) step(wt, O_MW, 1'b0, "to_wait");
    step(wt, O_ERR, 1'b0, "to_error");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), O_ERR, 1'b0, "err_sticky_rdy");
    step(mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 1), O_ERR, 1'b0, "err_sticky_lu");
    step(rs, O_RST, 1'b0, "err_reset");
    step(idle, O_NONE, 1'b0, "err_fresh_run");

    // Reset mid-wait and counter clear on return to RUN
    step(wt, O_MW, 1'b0, "mid_wait");
    step(wt, O_MW, 1'b0, "mid_wait");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_RST, 1'b0, "mid_wait_reset");
    for (int k = 0; k < int'(T); k++) step(wt, O_MW, 1'b0, "clr_wait_a");
    step(idle, O_NONE, 1'b0, "clr_release");
    for (int k = 0; k <= int'(T); k++) step(wt, O_MW, 1'b0, "clr_wait_b");
    step(idle, O_ERR, 1'b0, "clr_error");
    step(rs, O_RST, 1'b0, "clr_reset");

`ifdef PIPE_CTRL_PERF_EN
    // Three stall cycles then two flush cycles
    for (int k = 0; k < 3; k++) step(wt, O_MW, 1'b0, "perf_wait");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1), O_BR, 1'b0, "perf_br1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_BR, 1'b0, "perf_br2");
    step(idle, O_NONE, 1'b0, "perf_idle");
    check("perf_stall_total", stall_cycles, 32'd3);
    check("perf_flush_total", flush_events, 32'd2);
    step(rs, O_RST, 1'b0, "perf_reset");
`endif

    // Random traffic against the reference model
    for (int k = 0; k < 1500; k++) begin
      in_t x;
      x = mk($urandom_range(0, 59) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
             $urandom_range(0, 3) == 0);
      step(x, O_NONE, 1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max consecutive dmem wait cycles before error (range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset: rst, synchronous, active-high; clock clk.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source regs of instruction in ID.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-006 SHALL have port ex_rd  input  5  destination reg of instruction in EX.
REQ-007 SHALL have port ex_memr  input  1  EX instruction is a load.
REQ-008 SHALL have port br_taken  input  1  EX resolves taken branch/jump redirect.
REQ-009 SHALL have port mem_req  input  1  MEM-stage instruction accesses dmem (load or store).
REQ-010 SHALL have port dmem_ready  input  1  dmem completes access this cycle.
REQ-011 SHALL have ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  output  1 each  hold register.
REQ-012 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  load bubble into register.
REQ-013 SHALL have port mem_timeout  output  1  sticky dmem timeout error.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, ERROR; stall/flush outputs combinational from state and inputs, zero-latency.
REQ-015 SHALL detect load-use: ex_memr=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd or id_use_rs2 and id_rs2==ex_rd).
REQ-016 SHALL, in RUN on load-use without br_taken or mem wait: pc_stall=1, if_id_stall=1, id_ex_flush=1 for that cycle only.
REQ-017 SHALL, in RUN on br_taken without mem wait: if_id_flush=1, id_ex_flush=1, no stalls; load-use suppressed.
REQ-018 SHALL treat mem_req=1 and dmem_ready=0 as mem wait: pc, if_id, id_ex, ex_mem stalls=1, mem_wb_flush=1; br_taken and load-use ignored.
REQ-019 SHALL transition RUN->MEM_WAIT on mem wait; MEM_WAIT->RUN on cycle with dmem_ready=1 (outputs that cycle as RUN).
REQ-020 SHALL count wait cycles in 8-bit counter, cleared on entering RUN; on count==MEM_TIMEOUT with dmem_ready=0, go to ERROR.
REQ-021 SHALL, in ERROR, assert all five stalls, all flushes 0, mem_timeout=1, until rst.
REQ-022 SHALL drive ex_mem_flush=0 and mem_wb_stall=0 in RUN/MEM_WAIT; no other outputs asserted than listed per case.
REQ-023 SHALL priority-order: ERROR > mem wait > br_taken > load-use.

Reset
REQ-024 SHALL, while rst=1: state=RUN, counter=0, mem_timeout=0, all stalls 0, all four flushes 1.
REQ-025 SHALL allow rst mid MEM_WAIT or ERROR; next cycle after rst deasserts behaves as fresh RUN.

Configuration
REQ-026 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs stall_cycles and flush_events (32-bit, wrap at 2^32, cleared by rst).
REQ-027 SHALL increment stall_cycles per cycle pc_stall=1; flush_events per cycle if_id_flush or id_ex_flush=1 outside rst.
REQ-028 SHALL, without PIPE_CTRL_PERF_EN, omit those ports and counters; other behaviour identical.

Structure
REQ-029 SHALL place state enum pipe_ctrl_state_t and constant PIPE_CTRL_TIMEOUT_DEF=16 in package pipe_ctrl_pkg.
REQ-030 SHALL instantiate sub-module hazard_detect for REQ-015 combinational compare.

Verification
REQ-031 SHALL cover load-use: ex_memr=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 one cycle.
REQ-032 SHALL cover ex_rd=0 with same stimulus -> no stall, no flush.
REQ-033 SHALL cover br_taken=1 with concurrent load-use -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-034 SHALL cover mem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 stall cycles with mem_wb_flush=1, RUN after; br_taken ignored during wait.
REQ-035 SHALL cover MEM_TIMEOUT=4, dmem_ready held 0 -> ERROR, mem_timeout=1 after 5th wait cycle, cleared by rst.
REQ-036 SHALL cover PERF build: 3 stall cycles, 2 flush cycles -> stall_cycles=3, flush_events=2.
